// File: rtl/calc_bcd_seq.sv
// calc_bcd_seq: clocked switch/KEY calculator. A debounced key press picks
// add/sub/mul/pass on the SW operands. The result is converted to BCD by a
// serial shift-add-3 engine and shown as signed-magnitude on 7-seg digits.

// Per-key conditioner: 2-flop synchroniser plus stable-low counter that
// emits a single press pulse and re-arms only after the key reads high.
module calc_bcd_deb #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    // synchronise, count consecutive low cycles, saturate at DEB_CYCLES
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= key_n;
            s2    <= s1;
            press <= 1'b0;
            if (s2) begin
                cnt <= '0;
            end else if (cnt != CW'(DEB_CYCLES)) begin
                cnt <= cnt + CW'(1);
                if (cnt == CW'(DEB_CYCLES - 1))
                    press <= 1'b1;
            end
        end
    end
endmodule

module calc_bcd_seq #(
    parameter int OPW        = 5,
    parameter int DIGITS     = 4,
    parameter int DEB_CYCLES = 250000
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    input  logic [2*OPW-1:0]      SW,
    input  logic [3:0]            KEY,
    output logic [2*OPW-1:0]      LEDR,
    output logic                  NEG,
    output logic                  OVF,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [7*DIGITS-1:0]   HEX
);
    localparam int          RW    = 2 * OPW;
    localparam int          BW    = 4 * DIGITS;
    localparam int          CCW   = $clog2(RW + 1);
    localparam logic [31:0] LIMIT = 32'(10 ** (DIGITS - 1));
    localparam logic [6:0]  DASH  = 7'b0111111;
    localparam logic [6:0]  BLANK = 7'b1111111;
    localparam logic [6:0]  ZERO  = 7'b1000000;

    typedef enum logic [1:0] {IDLE, CALC, CONV, LOAD} state_t;

    state_t                     state, state_nxt;
    logic [3:0]                 press;
    logic                       any_press;
    logic [1:0]                 sel_op, op_q;
    logic [OPW-1:0]             a_q, b_q;
    logic [RW-1:0]              ax, bx, calc_mag;
    logic                       calc_neg, calc_ovf;
    logic [RW-1:0]              mag_q, sr_q, sr_nxt;
    logic                       neg_q, ovf_q;
    logic [DIGITS-1:0][3:0]     bcd_q, bcd_adj, bcd_nxt;
    logic [BW+RW-1:0]           cat;
    logic [CCW-1:0]             cc;
    logic [RW-1:0]              ledr_q;
    logic                       neg_o, ovf_o;
    logic [DIGITS-1:0][6:0]     hex_q, hex_nxt;
    logic                       seen;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_deb
            calc_bcd_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk   (CLOCK_50),
                .rst   (RESET),
                .key_n (KEY[k]),
                .press (press[k])
            );
        end
    endgenerate

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    // fixed-priority pick among simultaneous presses: KEY0 wins
    always_comb begin
        any_press = |press;
        sel_op    = 2'd3;
        if (press[0])      sel_op = 2'd0;
        else if (press[1]) sel_op = 2'd1;
        else if (press[2]) sel_op = 2'd2;
    end

    // state register
    always_ff @(posedge CLOCK_50) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state: one CALC cycle, RW CONV cycles, one LOAD cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_press) state_nxt = CALC;
            CALC:    state_nxt = CONV;
            CONV:    if (cc == CCW'(RW - 1)) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // arithmetic on the latched operands, all unsigned at RW bits
    always_comb begin
        ax       = {{OPW{1'b0}}, a_q};
        bx       = {{OPW{1'b0}}, b_q};
        calc_mag = '0;
        calc_neg = 1'b0;
        case (op_q)
            2'd0: calc_mag = ax + bx;
            2'd1: begin
                if (a_q < b_q) begin
                    calc_mag = bx - ax;
                    calc_neg = 1'b1;
                end else begin
                    calc_mag = ax - bx;
                end
            end
            2'd2:    calc_mag = ax * bx;
            default: calc_mag = {a_q, b_q};
        endcase
        calc_ovf = 32'(calc_mag) >= LIMIT;
    end

    // one double-dabble step: add 3 to nibbles >= 5, then shift left
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_q[i] >= 4'd5) bcd_adj[i] = bcd_q[i] + 4'd3;
        cat     = {bcd_adj, sr_q} << 1;
        bcd_nxt = cat[BW+RW-1:RW];
        sr_nxt  = cat[RW-1:0];
    end

    // display image from the final BCD step, leading zeros blanked
    always_comb begin
        hex_nxt = '1;
        seen    = 1'b0;
        if (ovf_q) begin
            for (int i = 0; i < DIGITS; i++) hex_nxt[i] = DASH;
        end else begin
            hex_nxt[DIGITS-1] = neg_q ? DASH : BLANK;
            for (int i = DIGITS - 2; i >= 0; i--) begin
                if (bcd_nxt[i] != 4'd0 || seen || i == 0) begin
                    hex_nxt[i] = seg(bcd_nxt[i]);
                    seen       = 1'b1;
                end
            end
        end
    end

    // datapath; outputs land on the edge entering LOAD so they appear
    // together with the DONE pulse
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 2'd0;
            mag_q  <= '0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
            sr_q   <= '0;
            bcd_q  <= '0;
            cc     <= '0;
            ledr_q <= '0;
            neg_o  <= 1'b0;
            ovf_o  <= 1'b0;
            hex_q  <= '1;
            hex_q[0] <= ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (any_press) begin
                        a_q  <= SW[2*OPW-1:OPW];
                        b_q  <= SW[OPW-1:0];
                        op_q <= sel_op;
                    end
                end
                CALC: begin
                    mag_q <= calc_mag;
                    neg_q <= calc_neg;
                    ovf_q <= calc_ovf;
                    sr_q  <= calc_mag;
                    bcd_q <= '0;
                    cc    <= '0;
                end
                CONV: begin
                    sr_q  <= sr_nxt;
                    bcd_q <= bcd_nxt;
                    cc    <= cc + CCW'(1);
                    if (cc == CCW'(RW - 1)) begin
                        ledr_q <= mag_q;
                        neg_o  <= neg_q;
                        ovf_o  <= ovf_q;
                        hex_q  <= hex_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign LEDR = ledr_q;
    assign NEG  = neg_o;
    assign OVF  = ovf_o;
    assign HEX  = hex_q;
    assign BUSY = (state != IDLE);
    assign DONE = (state == LOAD);
endmodule

// File: tb/tb_calc_bcd_seq.sv
// Directed bench for calc_bcd_seq: DIGITS=4 and DIGITS=3 instances share
// stimulus; expected values are hand-computed constants.
module tb_calc_bcd_seq;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S6 = 7'b0000010, S7 = 7'b1111000,
                           S9 = 7'b0010000, SM = 7'b0111111, SB = 7'b1111111;

    logic        clk = 1'b0;
    logic        RESET;
    logic [9:0]  SW;
    logic [3:0]  KEY;
    logic [9:0]  LEDR, LEDR3;
    logic        NEG, OVF, BUSY, DONE, NEG3, OVF3, BUSY3, DONE3;
    logic [27:0] HEX;
    logic [20:0] HEX3;

    int vecs = 0;
    int errs = 0;
    int done_cnt, first_done;
    logic b6, b7, b19;

    always #5 clk = ~clk;

    calc_bcd_seq #(.OPW(5), .DIGITS(4), .DEB_CYCLES(4)) dut (
        .CLOCK_50(clk), .RESET(RESET), .SW(SW), .KEY(KEY), .LEDR(LEDR),
        .NEG(NEG), .OVF(OVF), .BUSY(BUSY), .DONE(DONE), .HEX(HEX)
    );

    calc_bcd_seq #(.OPW(5), .DIGITS(3), .DEB_CYCLES(4)) dut3 (
        .CLOCK_50(clk), .RESET(RESET), .SW(SW), .KEY(KEY), .LEDR(LEDR3),
        .NEG(NEG3), .OVF(OVF3), .BUSY(BUSY3), .DONE(DONE3), .HEX(HEX3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // press keys m for hold cycles; optionally glitch-press im at iat (also
    // scrambling SW), optionally pulse RESET at rat; count DONE pulses
    task automatic do_op(input logic [3:0] m, input int hold, input logic [3:0] im,
                         input int iat, input int rat);
        @(negedge clk);
        KEY = ~m;
        done_cnt   = 0;
        first_done = -1;
        for (int n = 1; n <= hold + 30; n++) begin
            @(negedge clk);
            if (DONE) begin
                done_cnt++;
                if (first_done < 0) first_done = n;
            end
            if (n == 6)  b6  = BUSY;
            if (n == 7)  b7  = BUSY;
            if (n == 19) b19 = BUSY;
            if (n == hold) KEY = KEY | m;
            if (im != 4'h0 && n == iat) begin
                KEY = KEY & ~im;
                SW  = 10'h3FF;
            end
            if (im != 4'h0 && n == iat + 6) KEY = KEY | im;
            if (rat != 0 && n == rat)     RESET = 1'b1;
            if (rat != 0 && n == rat + 1) RESET = 1'b0;
        end
        KEY = 4'hF;
    endtask

    initial begin
        RESET = 1'b1;
        SW    = '0;
        KEY   = 4'hF;
        repeat (3) @(negedge clk);
        RESET = 1'b0;
        @(negedge clk);
        chk("rst_hex",  HEX,  {SB, SB, SB, S0});
        chk("rst_hex3", HEX3, {SB, SB, S0});
        chk("rst_ledr", LEDR, 10'd0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_negovf", {NEG, OVF}, 2'b00);

        // 25 + 7
        SW = {5'd25, 5'd7};
        do_op(4'b0001, 6, 4'h0, 0, 0);
        chk("add_dones", done_cnt, 1);
        chk("add_lat",   first_done, 18);
        chk("add_busy6", b6, 1'b0);
        chk("add_busy7", b7, 1'b1);
        chk("add_busy19", b19, 1'b0);
        chk("add_ledr",  LEDR, 10'd32);
        chk("add_hex",   HEX, {SB, SB, S3, S2});
        chk("add_negovf", {NEG, OVF}, 2'b00);

        // 3 - 20
        SW = {5'd3, 5'd20};
        do_op(4'b0010, 6, 4'h0, 0, 0);
        chk("sub_ledr", LEDR, 10'd17);
        chk("sub_neg",  NEG, 1'b1);
        chk("sub_hex",  HEX, {SM, SB, S1, S7});

        // 9 - 9
        SW = {5'd9, 5'd9};
        do_op(4'b0010, 6, 4'h0, 0, 0);
        chk("sub0_ledr", LEDR, 10'd0);
        chk("sub0_neg",  NEG, 1'b0);
        chk("sub0_hex",  HEX, {SB, SB, SB, S0});

        // 31 * 31 on both widths
        SW = {5'd31, 5'd31};
        do_op(4'b0100, 6, 4'h0, 0, 0);
        chk("mul_ledr",  LEDR, 10'd961);
        chk("mul_hex",   HEX, {SB, S9, S6, S1});
        chk("mul_ovf",   OVF, 1'b0);
        chk("mul3_hex",  HEX3, {SM, SM, SM});
        chk("mul3_ovf",  OVF3, 1'b1);
        chk("mul3_ledr", LEDR3, 10'd961);

        // reset in the middle of a multiply conversion
        do_op(4'b0100, 6, 4'h0, 0, 12);
        chk("mrst_dones", done_cnt, 0);
        chk("mrst_hex",   HEX, {SB, SB, SB, S0});
        chk("mrst_hex3",  HEX3, {SB, SB, S0});
        chk("mrst_ledr",  LEDR, 10'd0);
        chk("mrst_busy",  BUSY, 1'b0);
        chk("mrst_negovf", {NEG, OVF}, 2'b00);

        // KEY0+KEY2 together, KEY1 and SW change while busy
        SW = {5'd4, 5'd5};
        do_op(4'b0101, 6, 4'b0010, 8, 0);
        chk("pri_dones", done_cnt, 1);
        chk("pri_ledr",  LEDR, 10'd9);
        chk("pri_hex",   HEX, {SB, SB, SB, S9});
        chk("pri_neg",   NEG, 1'b0);

        // 2-cycle glitch: nothing happens
        SW = {5'd1, 5'd1};
        do_op(4'b0001, 2, 4'h0, 0, 0);
        chk("glitch_dones", done_cnt, 0);
        chk("glitch_ledr",  LEDR, 10'd9);

        // pass-through of the raw switch word
        SW = 10'b00011_00000;
        do_op(4'b1000, 6, 4'h0, 0, 0);
        chk("pass_ledr", LEDR, 10'd96);
        chk("pass_hex",  HEX, {SB, SB, S9, S6});

        // long hold gives one event; release and press again gives another
        SW = {5'd2, 5'd1};
        do_op(4'b0001, 100, 4'h0, 0, 0);
        chk("hold_dones", done_cnt, 1);
        chk("hold_lat",   first_done, 18);
        chk("hold_ledr",  LEDR, 10'd3);
        SW = {5'd2, 5'd5};
        do_op(4'b0001, 6, 4'h0, 0, 0);
        chk("rearm_dones", done_cnt, 1);
        chk("rearm_ledr",  LEDR, 10'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
